// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and multi-cycle stalls, branch flushes.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LATENCY     = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  input  logic                      load_e_i,
  input  logic                      pc_src_e_i,
  input  logic                      multicycle_e_i,
  output logic [1:0]                forward1_e_o,
  output logic [1:0]                forward2_e_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      stall_e_o,
  output logic                      flush_d_o,
  output logic                      flush_e_o,
  output logic                      bubble_m_o,
  output logic                      mc_done_o,
  output logic [31:0]               stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

  localparam logic [7:0] CNT_LOAD = 8'(MC_LATENCY - 2);

  mc_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lw_stall;
  logic       mc_stall;

  // Memory-stage result is newer than writeback, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic                      we_m,
    input logic [REG_ADDR_WIDTH-1:0] rd_w,
    input logic                      we_w
  );
    if (we_m && (rd_m == rs) && (rs != '0))      return 2'b01;
    else if (we_w && (rd_w == rs) && (rs != '0)) return 2'b10;
    else                                         return 2'b00;
  endfunction

  assign forward1_e_o = fwd_sel(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign forward2_e_o = fwd_sel(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);

  assign lw_stall = load_e_i && (rd_e_i != '0) &&
                    ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // Stall starts combinationally in the first execute cycle, before the FSM leaves IDLE.
  assign mc_stall = ((state_q == IDLE) && multicycle_e_i) || (state_q == BUSY);

  assign stall_f_o  = lw_stall || mc_stall;
  assign stall_d_o  = lw_stall || mc_stall;
  assign stall_e_o  = mc_stall;
  assign bubble_m_o = mc_stall;
  assign flush_d_o  = pc_src_e_i && !mc_stall;
  assign flush_e_o  = (lw_stall || pc_src_e_i) && !mc_stall;
  assign mc_done_o  = (state_q == DONE);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (multicycle_e_i) begin
          if (MC_LATENCY > 2) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (stall_d_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: driver pushes hand-computed expectations, negedge monitor compares.
// A second instance with MC_LATENCY=2 covers the shortest multi-cycle sequence.
module tb_hazard_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rwm, rww, load, pcsrc, mc;

  logic [1:0]  fwd1, fwd2;
  logic        st_f, st_d, st_e, fl_d, fl_e, bub_m, done;
  logic [31:0] scnt;
  logic [1:0]  fwd1_2, fwd2_2;
  logic        st_f2, st_d2, st_e2, fl_d2, fl_e2, bub_m2, done2;
  logic [31:0] scnt2;

  always #5 clk = ~clk;

  hazard_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(8)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_m_i(rwm), .reg_write_w_i(rww),
    .load_e_i(load), .pc_src_e_i(pcsrc), .multicycle_e_i(mc),
    .forward1_e_o(fwd1), .forward2_e_o(fwd2),
    .stall_f_o(st_f), .stall_d_o(st_d), .stall_e_o(st_e),
    .flush_d_o(fl_d), .flush_e_o(fl_e), .bubble_m_o(bub_m),
    .mc_done_o(done), .stall_cycles_o(scnt)
  );

  hazard_unit #(.REG_ADDR_WIDTH(5), .MC_LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n),
    .rs1_d_i(rs1_d), .rs2_d_i(rs2_d), .rs1_e_i(rs1_e), .rs2_e_i(rs2_e), .rd_e_i(rd_e),
    .rd_m_i(rd_m), .rd_w_i(rd_w), .reg_write_m_i(rwm), .reg_write_w_i(rww),
    .load_e_i(load), .pc_src_e_i(pcsrc), .multicycle_e_i(mc),
    .forward1_e_o(fwd1_2), .forward2_e_o(fwd2_2),
    .stall_f_o(st_f2), .stall_d_o(st_d2), .stall_e_o(st_e2),
    .flush_d_o(fl_d2), .flush_e_o(fl_e2), .bubble_m_o(bub_m2),
    .mc_done_o(done2), .stall_cycles_o(scnt2)
  );

  typedef struct {
    string       name;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [5:0]  ctl;   // {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m}
    logic        done;
    logic [1:0]  e2;    // {stall_e, mc_done} of the MC_LATENCY=2 instance
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   drv_done = 1'b0;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b110010;
  localparam logic [5:0] C_BR   = 6'b000110;
  localparam logic [5:0] C_MC   = 6'b111001;
  localparam logic [1:0] S2     = 2'b10;
  localparam logic [1:0] D2     = 2'b01;

  function automatic logic [31:0] pc(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp(input string nm, input logic [1:0] f1, input logic [1:0] f2,
                     input logic [5:0] ctl, input logic dn, input logic [1:0] e2,
                     input bit chk, input logic [31:0] cnt);
    exp_t e;
    e.name = nm; e.f1 = f1; e.f2 = f2; e.ctl = ctl; e.done = dn;
    e.e2 = e2; e.chk_cnt = chk; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Monitor: outputs have settled half a cycle after the driver changed inputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [12:0] act, req;
      e   = sb.pop_front();
      act = {fwd1, fwd2, st_f, st_d, st_e, fl_d, fl_e, bub_m, done};
      req = {e.f1, e.f2, e.ctl, e.done};
      n_cmp++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s: got f1f2ctl_done=%b want %b", e.name, act, req);
      end
      n_cmp++;
      if ({st_e2, done2} !== e.e2) begin
        n_fail++;
        $display("FAIL %s lat2: got stall_e,done=%b want %b", e.name, {st_e2, done2}, e.e2);
      end
      if (e.chk_cnt) begin
        n_cmp++;
        if (scnt !== e.cnt) begin
          n_fail++;
          $display("FAIL %s stall_cycles: got %0d want %0d", e.name, scnt, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rwm, rww, load, pcsrc, mc} = '0;

    cyc(); exp("reset", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b1, 32'd0);
    cyc(); rst_n = 1'b1;
    exp("post_reset", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b1, 32'd0);

    // Forwarding
    cyc(); rd_m = 5; rwm = 1; rd_w = 5; rww = 1; rs1_e = 5;
    exp("fwd1_mem_prio", 2'b01, 2'b00, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rwm = 0;
    exp("fwd1_wb", 2'b10, 2'b00, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rs1_e = 0;
    exp("fwd1_x0", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rs2_e = 3; rd_m = 3; rwm = 1;
    exp("fwd2_mem", 2'b00, 2'b01, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rs2_e = 0; rd_m = 0;
    exp("fwd2_x0", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rs1_e = 7; rd_w = 7; rd_m = 2; rs2_e = 2;
    exp("fwd_split", 2'b10, 2'b01, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rwm = 0; rww = 0; rs1_e = 0; rs2_e = 0;

    // Load-use stalls (three counted) and branch flush
    load = 1; rd_e = 7; rs2_d = 7;
    exp("lw_rs2", 2'b00, 2'b00, C_LW, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rs1_d = 7; rs2_d = 0;
    exp("lw_rs1", 2'b00, 2'b00, C_LW, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rd_e = 0; rs1_d = 0;
    exp("lw_rd_x0", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); rd_e = 4; rs1_d = 4;
    exp("lw_third", 2'b00, 2'b00, C_LW, 1'b0, 2'b00, 1'b0, 32'd0);
    cyc(); load = 0; pcsrc = 1;
    exp("branch_flush", 2'b00, 2'b00, C_BR, 1'b0, 2'b00, 1'b1, pc(3));

    // Full multi-cycle op, operand held for all eight cycles
    cyc(); pcsrc = 0; mc = 1;
    exp("mc_c1", 2'b00, 2'b00, C_MC, 1'b0, S2, 1'b0, 32'd0);
    for (int i = 2; i <= 7; i++) begin
      cyc();
      exp($sformatf("mc_c%0d", i), 2'b00, 2'b00, C_MC, 1'b0, (i % 2 == 0) ? D2 : S2,
          1'b0, 32'd0);
    end
    cyc(); exp("mc_done", 2'b00, 2'b00, C_NONE, 1'b1, D2, 1'b1, pc(10));
    cyc(); mc = 0;
    exp("mc_idle", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b1, pc(10));

    // Flush suppression while busy, then async reset in cycle 4
    cyc(); mc = 1;
    exp("mcb_c1", 2'b00, 2'b00, C_MC, 1'b0, S2, 1'b0, 32'd0);
    cyc(); pcsrc = 1; load = 1; rd_e = 6; rs1_d = 6;
    exp("busy_no_flush", 2'b00, 2'b00, C_MC, 1'b0, D2, 1'b0, 32'd0);
    cyc(); exp("busy_no_flush2", 2'b00, 2'b00, C_MC, 1'b0, S2, 1'b0, 32'd0);
    cyc(); rst_n = 0; mc = 0; pcsrc = 0; load = 0;
    exp("reset_in_busy", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b1, 32'd0);
    cyc(); rst_n = 1; mc = 1;
    exp("restart_c1", 2'b00, 2'b00, C_MC, 1'b0, S2, 1'b0, 32'd0);
    for (int i = 2; i <= 7; i++) begin
      cyc();
      exp($sformatf("restart_c%0d", i), 2'b00, 2'b00, C_MC, 1'b0, (i % 2 == 0) ? D2 : S2,
          1'b0, 32'd0);
    end
    cyc(); exp("restart_done", 2'b00, 2'b00, C_NONE, 1'b1, D2, 1'b1, pc(7));
    cyc(); mc = 0;
    exp("restart_idle", 2'b00, 2'b00, C_NONE, 1'b0, 2'b00, 1'b1, pc(7));

    cyc(); cyc();
    drv_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!drv_done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_cmp++;
    if (!drv_done || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: driver_done=%0d pending=%0d want 1 and 0", drv_done, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
